// File: rtl/joypad_port.sv
// Dendy controller port responder for $4016/$4017.
// A strobe write to $4016 latches both pads; each CPU read then returns one
// button in bit 0 (bit 6 set for open-bus compatibility) and shifts the
// addressed pad register by one, back-filling with ones. A/B can be
// auto-fired by a frame-driven turbo phase.
module joypad_port #(
  parameter int unsigned TURBO_FRAMES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce_cpu,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_o,
  input  logic        cpu_w,
  input  logic        cpu_r,
  output logic [7:0]  cpu_i,
  output logic        cpu_hit,
  input  logic        frame,
  input  logic [7:0]  pad1,
  input  logic [7:0]  pad2,
  input  logic [1:0]  turbo1,
  input  logic [1:0]  turbo2
);

  localparam int unsigned CW = (TURBO_FRAMES > 1) ? $clog2(TURBO_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TURBO_FRAMES - 1);

  logic [CW-1:0] frame_cnt;
  logic          phase;
  logic          strobe;
  logic [7:0]    sr1;
  logic [7:0]    sr2;
  logic [7:0]    eff1;
  logic [7:0]    eff2;
  logic          sel_4016;
  logic          sel_4017;
  logic          wr_strobe;
  logic          shift_en;

  assign sel_4016  = (cpu_a == 16'h4016);
  assign sel_4017  = (cpu_a == 16'h4017);
  assign cpu_hit   = cpu_r & (sel_4016 | sel_4017);
  assign wr_strobe = ce_cpu & cpu_w & sel_4016;
  // A simultaneous write wins over the read-side shift.
  assign shift_en  = ce_cpu & cpu_r & ~cpu_w & cpu_hit & ~strobe;

  // Effective button state with turbo phase ORed into A and B.
  always_comb begin
    eff1 = {pad1[7:2], pad1[1] | (turbo1[1] & phase), pad1[0] | (turbo1[0] & phase)};
    eff2 = {pad2[7:2], pad2[1] | (turbo2[1] & phase), pad2[0] | (turbo2[0] & phase)};
  end

  // Turbo timebase: toggle phase every TURBO_FRAMES frame pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (frame) begin
      if (frame_cnt == CNT_LAST) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Strobe latch and pad shift registers.
  // Reload is gated by the registered strobe, so the clock on which the
  // strobe-clear write commits still reloads and that sample is what is held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      strobe <= 1'b0;
      sr1    <= '0;
      sr2    <= '0;
    end else begin
      if (wr_strobe)
        strobe <= cpu_o[0];
      if (strobe) begin
        sr1 <= eff1;
        sr2 <= eff2;
      end else if (shift_en) begin
        if (sel_4016)
          sr1 <= {1'b1, sr1[7:1]};
        else
          sr2 <= {1'b1, sr2[7:1]};
      end
    end
  end

  // Read data: live button while strobe is high, else the register LSB.
  always_comb begin
    cpu_i = 8'h00;
    if (cpu_hit) begin
      if (sel_4016)
        cpu_i = {7'b0100000, strobe ? eff1[0] : sr1[0]};
      else
        cpu_i = {7'b0100000, strobe ? eff2[0] : sr2[0]};
    end
  end

endmodule

// File: tb/tb_joypad_port.sv
// Directed bench for joypad_port: table of bus operations plus hand-written
// multi-cycle sequences for turbo, ce_cpu gating and reset.
module tb_joypad_port;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ce_cpu = 1'b0;
  logic [15:0] cpu_a = 16'h0000;
  logic [7:0]  cpu_o = 8'h00;
  logic        cpu_w = 1'b0;
  logic        cpu_r = 1'b0;
  logic [7:0]  cpu_i;
  logic        cpu_hit;
  logic        frame = 1'b0;
  logic [7:0]  pad1 = 8'h00;
  logic [7:0]  pad2 = 8'h00;
  logic [1:0]  turbo1 = 2'b00;
  logic [1:0]  turbo2 = 2'b00;

  int unsigned errors = 0;
  int unsigned checks = 0;

  joypad_port #(.TURBO_FRAMES(2)) dut (
    .clock  (clock),
    .reset  (reset),
    .ce_cpu (ce_cpu),
    .cpu_a  (cpu_a),
    .cpu_o  (cpu_o),
    .cpu_w  (cpu_w),
    .cpu_r  (cpu_r),
    .cpu_i  (cpu_i),
    .cpu_hit(cpu_hit),
    .frame  (frame),
    .pad1   (pad1),
    .pad2   (pad2),
    .turbo1 (turbo1),
    .turbo2 (turbo2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  p1;
    logic [7:0]  p2;
    logic [7:0]  exp;
    logic        exp_hit;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t rd(input logic [15:0] a, input logic [7:0] p1,
                              input logic [7:0] p2, input logic [7:0] exp,
                              input logic hit);
    vec_t v;
    v.wr = 1'b0; v.a = a; v.d = 8'h00; v.p1 = p1; v.p2 = p2; v.exp = exp; v.exp_hit = hit;
    return v;
  endfunction

  function automatic vec_t wr(input logic [15:0] a, input logic [7:0] d,
                              input logic [7:0] p1, input logic [7:0] p2);
    vec_t v;
    v.wr = 1'b1; v.a = a; v.d = d; v.p1 = p1; v.p2 = p2; v.exp = 8'h00; v.exp_hit = 1'b0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    cpu_a = a; cpu_o = d; cpu_w = 1'b1; ce_cpu = 1'b1;
    @(posedge clock);
    #1;
    cpu_w = 1'b0; ce_cpu = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [15:0] a,
                          input logic [7:0] exp, input logic exp_hit);
    @(negedge clock);
    cpu_a = a; cpu_r = 1'b1; ce_cpu = 1'b1;
    #1;
    chk({name, ".data"}, cpu_i, exp);
    chk({name, ".hit"}, {7'd0, cpu_hit}, {7'd0, exp_hit});
    @(posedge clock);
    #1;
    cpu_r = 1'b0; ce_cpu = 1'b0;
  endtask

  task automatic latch_pads();
    bus_write(16'h4016, 8'h01);
    bus_write(16'h4016, 8'h00);
  endtask

  task automatic frame_pulse();
    @(negedge clock);
    frame = 1'b1;
    @(posedge clock);
    #1;
    frame = 1'b0;
  endtask

  initial begin
    // Reset state with no access in progress.
    #2;
    chk("reset.cpu_i", cpu_i, 8'h00);
    chk("reset.hit", {7'd0, cpu_hit}, 8'h00);
    do_reset();

    // Case 1: idle after reset, plus a non-port read.
    for (int i = 0; i < 3; i++) tbl.push_back(rd(16'h4016, 8'h00, 8'h00, 8'h40, 1'b1));
    for (int i = 0; i < 3; i++) tbl.push_back(rd(16'h4017, 8'h00, 8'h00, 8'h40, 1'b1));
    tbl.push_back(rd(16'h4015, 8'h00, 8'h00, 8'h00, 1'b0));
    // Case 2: pad1=81 latched, ten reads.
    tbl.push_back(wr(16'h4016, 8'h01, 8'h81, 8'h00));
    tbl.push_back(wr(16'h4016, 8'h00, 8'h81, 8'h00));
    tbl.push_back(rd(16'h4016, 8'h81, 8'h00, 8'h41, 1'b1));
    for (int i = 0; i < 6; i++) tbl.push_back(rd(16'h4016, 8'h81, 8'h00, 8'h40, 1'b1));
    for (int i = 0; i < 3; i++) tbl.push_back(rd(16'h4016, 8'h81, 8'h00, 8'h41, 1'b1));
    // Case 4: pad2=02 latched, interleaved reads of both ports.
    tbl.push_back(wr(16'h4016, 8'h01, 8'h00, 8'h02));
    tbl.push_back(wr(16'h4016, 8'hFE, 8'h00, 8'h02));
    tbl.push_back(rd(16'h4017, 8'h00, 8'h02, 8'h40, 1'b1));
    tbl.push_back(rd(16'h4016, 8'h00, 8'h02, 8'h40, 1'b1));
    tbl.push_back(rd(16'h4017, 8'h00, 8'h02, 8'h41, 1'b1));
    tbl.push_back(rd(16'h4016, 8'h00, 8'h02, 8'h40, 1'b1));
    tbl.push_back(rd(16'h4017, 8'h00, 8'h02, 8'h40, 1'b1));

    foreach (tbl[i]) begin
      pad1 = tbl[i].p1;
      pad2 = tbl[i].p2;
      if (tbl[i].wr)
        bus_write(tbl[i].a, tbl[i].d);
      else
        bus_read($sformatf("tbl%0d", i), tbl[i].a, tbl[i].exp, tbl[i].exp_hit);
    end

    // Case 3: strobe held high returns the live A button, no shifting.
    bus_write(16'h4016, 8'h01);
    pad1 = 8'h00; bus_read("live0", 16'h4016, 8'h40, 1'b1);
    pad1 = 8'h01; bus_read("live1", 16'h4016, 8'h41, 1'b1);
    pad1 = 8'h00; bus_read("live2", 16'h4016, 8'h40, 1'b1);
    bus_write(16'h4016, 8'h00);

    // Case 5: turbo on pad1 A, phase toggles every two frames.
    do_reset();
    pad1 = 8'h00; turbo1 = 2'b01;
    frame_pulse(); frame_pulse();
    latch_pads();
    bus_read("turbo_on", 16'h4016, 8'h41, 1'b1);
    frame_pulse(); frame_pulse();
    latch_pads();
    bus_read("turbo_off", 16'h4016, 8'h40, 1'b1);
    frame_pulse();
    latch_pads();
    bus_read("turbo_half", 16'h4016, 8'h40, 1'b1);
    turbo1 = 2'b00;

    // Case 6: reads without ce_cpu must not shift.
    do_reset();
    pad1 = 8'h02;
    latch_pads();
    @(negedge clock);
    cpu_a = 16'h4016; cpu_r = 1'b1; ce_cpu = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("noce%0d", i), cpu_i, 8'h40);
      @(negedge clock);
    end
    cpu_r = 1'b0;
    bus_read("ce_read0", 16'h4016, 8'h40, 1'b1);
    bus_read("ce_read1", 16'h4016, 8'h41, 1'b1);
    // Write to $4017 must not set strobe; live pad would read 41.
    pad1 = 8'h01;
    bus_write(16'h4017, 8'h01);
    bus_read("w4017", 16'h4016, 8'h40, 1'b1);
    // Read and write together: write lands, no shift.
    bus_write(16'h4016, 8'h00);
    @(negedge clock);
    cpu_a = 16'h4016; cpu_r = 1'b1; cpu_w = 1'b1; cpu_o = 8'h01; ce_cpu = 1'b1;
    @(posedge clock);
    #1;
    cpu_w = 1'b0; ce_cpu = 1'b0; cpu_r = 1'b0;
    bus_read("rw_strobe", 16'h4016, 8'h41, 1'b1);
    // Reset mid-sequence clears strobe and registers.
    do_reset();
    bus_read("post_reset0", 16'h4016, 8'h40, 1'b1);
    bus_read("post_reset1", 16'h4017, 8'h40, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
